// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding,
//   byte-enable shorthands and the port numbering used by dmem_arbiter.
//   Optional feature macro used by the top: DMEM_ARB_RR_EN (round-robin).
package dmem_arb_pkg;

  // IDLE arbitrates and serves single-cycle accesses; RMW_WR is the second
  // (write-back) cycle of a sub-word store.
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  // One-hot grant vector for the selected port.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge
//   Combinational 4-lane byte merge used for sub-word stores: each byte lane
//   takes the new write data where its enable is set, otherwise keeps the
//   word currently held in memory.
// Ports:
//   wdata  - incoming store data
//   rdata  - current memory word
//   be     - byte enables, bit k selects byte lane k
//   merged - resulting word to write back
module dmem_byte_merge (
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  // Lane-by-lane select between new data and the old memory contents.
  always_comb begin
    merged = rdata;
    for (int lane = 0; lane < 4; lane++) begin
      if (be[lane]) begin
        merged[lane*8 +: 8] = wdata[lane*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter/sequencer in front of a single data memory. Port 0 is
//   the core load/store path, port 1 the DMA/debug loader. Byte addresses are
//   reduced to word indices (modulo MEM_WORDS), reads return registered data
//   one cycle after the grant, and sub-word stores are done as an atomic
//   read-modify-write spanning two cycles.
//   Optional feature macro: DMEM_ARB_RR_EN
//     undefined - fixed priority, port 0 wins every tie
//     defined   - round-robin, tie goes to the port not granted last
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req, we           - per-port request and write flag
//   addr, wdata, be   - per-port byte address, write data, byte enables
//   gnt               - one-cycle grant pulse (at most one bit set)
//   rvalid, rdata     - read-data-valid pulse per port, shared read data
//   busy              - high during the write-back cycle of an RMW
//   mem_*             - control/data pins of the data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  input  logic [7:0]              be,
  output logic [1:0]              gnt,
  output logic [1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [ADDR_WIDTH-1:0]   mem_w_address,
  output logic [ADDR_WIDTH-1:0]   mem_r_address,
  output logic [DATA_WIDTH-1:0]   mem_wd,
  input  logic [DATA_WIDTH-1:0]   mem_rd
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  arb_state_e state_q, state_d;

  logic                  sel_port;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            sel_be;
  logic [IDX_W-1:0]      sel_idx;
  logic [ADDR_WIDTH-1:0] sel_idx_ext;
  logic [ADDR_WIDTH-1:0] rmw_idx_ext;
  logic                  accept;
  logic                  is_read;
  logic                  is_full_wr;
  logic                  is_part_wr;
  logic [DATA_WIDTH-1:0] merged;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rvalid_q, rvalid_d;

  // Byte-offset bits and bits above the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[ADDR_WIDTH-1:IDX_W+2]};

`ifdef DMEM_ARB_RR_EN
  // Port granted most recently; resets to the DMA port so the core wins the
  // first tie after reset.
  logic last_q, last_d;

  always_comb begin
    sel_port = 1'b0;
    if (req == 2'b11) begin
      sel_port = ~last_q;
    end else begin
      sel_port = req[PORT_DMA];
    end
  end
`else
  // Fixed priority: the DMA port is only chosen when the core is not asking.
  always_comb begin
    sel_port = ~req[PORT_CORE] & req[PORT_DMA];
  end
`endif

  // Route the selected requester's command onto the shared datapath.
  always_comb begin
    sel_we    = sel_port ? we[PORT_DMA] : we[PORT_CORE];
    sel_addr  = sel_port ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
    sel_wdata = sel_port ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
    sel_be    = sel_port ? be[7:4] : be[3:0];
    sel_idx   = sel_addr[IDX_W+1:2];
  end

  assign sel_idx_ext = {{(ADDR_WIDTH-IDX_W){1'b0}}, sel_idx};
  assign rmw_idx_ext = {{(ADDR_WIDTH-IDX_W){1'b0}}, idx_q};

  // A request is only accepted from IDLE; while reset is asserted nothing is
  // granted so every output reads back as zero.
  always_comb begin
    accept     = (state_q == IDLE) && (req != 2'b00) && !rst;
    is_read    = accept && !sel_we;
    is_full_wr = accept && sel_we && (sel_be == BE_FULL);
    is_part_wr = accept && sel_we && (sel_be != BE_FULL) && (sel_be != BE_NONE);
  end

  dmem_byte_merge u_merge (
    .wdata  (sel_wdata),
    .rdata  (mem_rd),
    .be     (sel_be),
    .merged (merged)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only a partial store leaves IDLE, and the write-back
  // cycle always returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_part_wr) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant and memory control. A partial store reads in its grant
  // cycle and writes the merged word in the following RMW_WR cycle.
  always_comb begin
    gnt           = 2'b00;
    busy          = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_w_address = '0;
    mem_r_address = '0;
    mem_wd        = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt = port_onehot(sel_port);
        end
        if (is_read || is_part_wr) begin
          mem_re        = 1'b1;
          mem_r_address = sel_idx_ext;
        end
        if (is_full_wr) begin
          mem_we        = 1'b1;
          mem_w_address = sel_idx_ext;
          mem_wd        = sel_wdata;
        end
      end
      RMW_WR: begin
        busy          = 1'b1;
        mem_we        = 1'b1;
        mem_w_address = rmw_idx_ext;
        mem_wd        = merge_q;
      end
      default: ;
    endcase
  end

  // Datapath next values: capture read data on a read grant, capture the
  // merged word and its index on a partial-store grant.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    merge_d  = merge_q;
    idx_d    = idx_q;
    if (is_read) begin
      rdata_d  = mem_rd;
      rvalid_d = port_onehot(sel_port);
    end
    if (is_part_wr) begin
      merge_d = merged;
      idx_d   = sel_idx;
    end
  end

  // Datapath registers; reset drops any pending merged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
      merge_q  <= '0;
      idx_q    <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      merge_q  <= merge_d;
      idx_q    <= idx_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer follows every accepted request.
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = sel_port;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A behavioural word memory answers
//   the DUT's memory pins, and a separate reference array holds the contents
//   the memory should have according to the access rules.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_w_address;
  logic [31:0] mem_r_address;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks;
  int failures;

  logic [31:0] tb_mem [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023];

  typedef struct {
    logic        ok;
    logic [1:0]  g;
    logic        g_we;
    logic        g_re;
    logic [31:0] g_wa;
    logic [31:0] g_ra;
    logic [31:0] g_wd;
    logic [1:0]  n_rv;
    logic [31:0] n_rd;
    logic        n_busy;
    logic        n_we;
    logic [31:0] n_wa;
    logic [31:0] n_wd;
  } obs_t;

  dmem_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_WORDS  (1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .be            (be),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .busy          (busy),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_w_address (mem_w_address),
    .mem_r_address (mem_r_address),
    .mem_wd        (mem_wd),
    .mem_rd        (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT: combinational read, write on the rising edge.
  assign mem_rd = tb_mem[mem_r_address[9:0]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_w_address[9:0]] <= mem_wd;
  end

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Presents one request on port p, waits (bounded) for its grant, and
  // records what the memory pins did in the grant cycle and the next one.
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, output obs_t o);
    o = '{default: '0};
    @(posedge clk); #1;
    req[p] = 1'b1;
    we[p] = w;
    addr[p*32 +: 32] = a;
    wdata[p*32 +: 32] = d;
    be[p*4 +: 4] = b;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gnt[p]) begin
        o.ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    o.g    = gnt;
    o.g_we = mem_we;
    o.g_re = mem_re;
    o.g_wa = mem_w_address;
    o.g_ra = mem_r_address;
    o.g_wd = mem_wd;
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
    o.n_rv   = rvalid;
    o.n_rd   = rdata;
    o.n_busy = busy;
    o.n_we   = mem_we;
    o.n_wa   = mem_w_address;
    o.n_wd   = mem_wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, busy, mem_we, mem_re} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0", {gnt, rvalid, busy, mem_we, mem_re});
    end
    checks++;
    if ({rdata, mem_w_address, mem_r_address, mem_wd} !== 128'b0) begin
      failures++;
      $display("[TB] FAIL reset_data rdata=%h wa=%h ra=%h wd=%h exp=0",
               rdata, mem_w_address, mem_r_address, mem_wd);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_write_read();
    obs_t o;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, o);
    ref_mem[word_of(32'h10)] = 32'hDEADBEEF;
    checks++;
    if (!o.ok || o.g !== 2'b01 || o.g_we !== 1'b1 || o.g_wa !== 32'd4 || o.g_wd !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL full_write ok=%b gnt=%b we=%b wa=%h wd=%h exp gnt=01 we=1 wa=4 wd=deadbeef",
               o.ok, o.g, o.g_we, o.g_wa, o.g_wd);
    end
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, o);
    checks++;
    if (!o.ok || o.g_re !== 1'b1 || o.g_ra !== 32'd4) begin
      failures++;
      $display("[TB] FAIL read_addr ok=%b re=%b ra=%h exp re=1 ra=4", o.ok, o.g_re, o.g_ra);
    end
    checks++;
    if (o.n_rv !== 2'b01 || o.n_rd !== ref_mem[4]) begin
      failures++;
      $display("[TB] FAIL read_data rvalid=%b rdata=%h exp rvalid=01 rdata=%h", o.n_rv, o.n_rd, ref_mem[4]);
    end
  endtask

  task automatic test_rmw();
    obs_t o;
    logic [31:0] exp;
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, o);
    ref_mem[8] = 32'h11223344;
    exp = apply_be(ref_mem[8], 32'hAABBCCDD, 4'b0101);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[63:32] = 32'h20; wdata[63:32] = 32'hAABBCCDD; be[7:4] = 4'b0101;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || mem_re !== 1'b1 || mem_r_address !== 32'd8) begin
      failures++;
      $display("[TB] FAIL rmw_grant gnt=%b re=%b ra=%h exp gnt=10 re=1 ra=8", gnt, mem_re, mem_r_address);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[31:0] = 32'h20;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || gnt !== 2'b00 || mem_we !== 1'b1 || mem_w_address !== 32'd8 || mem_wd !== exp) begin
      failures++;
      $display("[TB] FAIL rmw_writeback busy=%b gnt=%b we=%b wa=%h wd=%h exp busy=1 gnt=00 we=1 wa=8 wd=%h",
               busy, gnt, mem_we, mem_w_address, mem_wd, exp);
    end
    ref_mem[8] = exp;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rmw_release gnt=%b busy=%b exp gnt=01 busy=0", gnt, busy);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 32'h11BB33DD) begin
      failures++;
      $display("[TB] FAIL rmw_readback rvalid=%b rdata=%h exp rvalid=01 rdata=11bb33dd", rvalid, rdata);
    end
  endtask

  task automatic test_be_none();
    obs_t o;
    issue(1, 1'b1, 32'h30, 32'h5, 4'hF, o);
    ref_mem[12] = 32'h5;
    issue(1, 1'b1, 32'h30, $urandom, 4'h0, o);
    checks++;
    if (!o.ok || o.g !== 2'b10 || o.g_we !== 1'b0 || o.n_we !== 1'b0 || o.n_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL be_none ok=%b gnt=%b we=%b/%b busy=%b exp gnt=10 we=0/0 busy=0",
               o.ok, o.g, o.g_we, o.n_we, o.n_busy);
    end
    issue(1, 1'b0, 32'h30, 32'h0, 4'h0, o);
    checks++;
    if (o.n_rv !== 2'b10 || o.n_rd !== ref_mem[12]) begin
      failures++;
      $display("[TB] FAIL be_none_read rvalid=%b rdata=%h exp rvalid=10 rdata=%h", o.n_rv, o.n_rd, ref_mem[12]);
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    logic [31:0] v;
    v = $urandom;
    issue(0, 1'b1, 32'h0, v, 4'hF, o);
    ref_mem[0] = v;
    issue(0, 1'b0, 32'h1003, 32'h0, 4'h0, o);
    checks++;
    if (o.g_ra !== 32'd0 || o.n_rv !== 2'b01 || o.n_rd !== ref_mem[word_of(32'h1003)]) begin
      failures++;
      $display("[TB] FAIL wrap ra=%h rvalid=%b rdata=%h exp ra=0 rvalid=01 rdata=%h",
               o.g_ra, o.n_rv, o.n_rd, ref_mem[0]);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    req = 2'b11; we = 2'b00;
    addr = {32'h20, 32'h10};
    prev_g = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      checks++;
      if (gnt !== exp_g) begin
        failures++;
        $display("[TB] FAIL tie_gnt[%0d] got=%b exp=%b", i, gnt, exp_g);
      end
      if (i > 0) begin
        checks++;
        if (rvalid !== prev_g || rdata !== (prev_g[1] ? ref_mem[8] : ref_mem[4])) begin
          failures++;
          $display("[TB] FAIL tie_rvalid[%0d] rvalid=%b rdata=%h exp rvalid=%b rdata=%h", i, rvalid, rdata,
                   prev_g, prev_g[1] ? ref_mem[8] : ref_mem[4]);
        end
      end
      prev_g = exp_g;
      @(posedge clk); #1;
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_rmw();
    obs_t o;
    issue(0, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, o);
    ref_mem[20] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[31:0] = 32'h50; wdata[31:0] = $urandom; be[3:0] = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("[TB] FAIL midrmw_grant got=%b exp=01", gnt);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrmw_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, rvalid, busy, mem_we, mem_re, rdata, mem_wd, mem_w_address, mem_r_address} !== 135'b0) begin
      failures++;
      $display("[TB] FAIL midrmw_outputs gnt=%b rv=%b busy=%b we=%b re=%b rdata=%h wd=%h wa=%h ra=%h exp all 0",
               gnt, rvalid, busy, mem_we, mem_re, rdata, mem_wd, mem_w_address, mem_r_address);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 1'b0, 32'h50, 32'h0, 4'h0, o);
    checks++;
    if (o.n_rv !== 2'b01 || o.n_rd !== ref_mem[20]) begin
      failures++;
      $display("[TB] FAIL midrmw_untouched rvalid=%b rdata=%h exp rvalid=01 rdata=%h", o.n_rv, o.n_rd, ref_mem[20]);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int p, op, idx;
    logic [31:0] a, d;
    logic [3:0] b;
    for (int n = 0; n < 80; n++) begin
      p  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 12);
      d  = $urandom;
      idx = word_of(a);
      case (op)
        1:       b = 4'hF;
        2:       b = 4'($urandom_range(1, 14));
        3:       b = 4'h0;
        default: b = 4'h0;
      endcase
      issue(p, op != 0, a, d, b, o);
      checks++;
      if (!o.ok || o.g !== (p == 1 ? 2'b10 : 2'b01)) begin
        failures++;
        $display("[TB] FAIL rnd_grant[%0d] ok=%b gnt=%b port=%0d", n, o.ok, o.g, p);
      end
      checks++;
      if (op == 0) begin
        if (o.g_ra !== 32'(idx) || o.n_rv !== (p == 1 ? 2'b10 : 2'b01) || o.n_rd !== ref_mem[idx]) begin
          failures++;
          $display("[TB] FAIL rnd_read[%0d] ra=%h rvalid=%b rdata=%h exp ra=%h rdata=%h",
                   n, o.g_ra, o.n_rv, o.n_rd, idx, ref_mem[idx]);
        end
      end else if (op == 1) begin
        if (o.g_we !== 1'b1 || o.g_wa !== 32'(idx) || o.g_wd !== d || o.n_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rnd_full[%0d] we=%b wa=%h wd=%h busy=%b exp wa=%h wd=%h",
                   n, o.g_we, o.g_wa, o.g_wd, o.n_busy, idx, d);
        end
        ref_mem[idx] = d;
      end else if (op == 2) begin
        if (o.g_we !== 1'b0 || o.n_busy !== 1'b1 || o.n_we !== 1'b1 || o.n_wa !== 32'(idx) ||
            o.n_wd !== apply_be(ref_mem[idx], d, b)) begin
          failures++;
          $display("[TB] FAIL rnd_partial[%0d] busy=%b we=%b wa=%h wd=%h exp wa=%h wd=%h",
                   n, o.n_busy, o.n_we, o.n_wa, o.n_wd, idx, apply_be(ref_mem[idx], d, b));
        end
        ref_mem[idx] = apply_be(ref_mem[idx], d, b);
      end else begin
        if (o.g_we !== 1'b0 || o.n_we !== 1'b0 || o.n_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rnd_none[%0d] we=%b/%b busy=%b exp 0", n, o.g_we, o.n_we, o.n_busy);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
    rst = 1'b1;
    test_reset();
    test_full_write_read();
    test_rmw();
    test_be_none();
    test_wrap();
    test_tie();
    test_reset_mid_rmw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter/sequencer in front of data_memory: shares the single memory between the core load/store path (port 0) and a DMA/debug loader (port 1). Converts byte addresses to word indices, returns registered read data, and performs read-modify-write for sub-word stores. Owns all data_memory control pins (we, re, w_address, r_address, wd) and samples rd.

Parameters:
DATA_WIDTH, 32, data word width (fixed 32; byte enables assume 4 lanes)
ADDR_WIDTH, 32, requester byte-address width and memory address-port width
MEM_WORDS, 1024, memory depth in words; word index width IDX_W = clog2(MEM_WORDS)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
req  in  2  request per port; bit0 core, bit1 DMA
we  in  2  1 = write, 0 = read, per port
addr  in  2*ADDR_WIDTH  byte address per port; port n = addr[n*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  2*DATA_WIDTH  write data per port
be  in  8  byte enables per port, 4 bits each
gnt  out  2  one-cycle grant pulse, at most one bit set
rvalid  out  2  read-data-valid pulse, one cycle after read grant
rdata  out  DATA_WIDTH  registered read data, shared, qualified by rvalid
busy  out  1  high while in RMW_WR
mem_we  out  1  to data_memory we
mem_re  out  1  to data_memory re (high in any cycle that reads rd)
mem_w_address  out  ADDR_WIDTH  word index, zero-extended
mem_r_address  out  ADDR_WIDTH  word index, zero-extended
mem_wd  out  DATA_WIDTH  write data to memory
mem_rd  in  DATA_WIDTH  combinational read data from memory

Behaviour:
- Reset (async, any state): state IDLE; gnt, rvalid, busy, mem_we, mem_re = 0; rdata, merge register, addresses, mem_wd = 0; any pending RMW write is dropped, memory untouched.
- Word index = addr[IDX_W+1:2]; addr[1:0] ignored; upper bits ignored (wrap modulo MEM_WORDS).
- States: IDLE, RMW_WR. Only IDLE arbitrates. gnt is combinational from req in IDLE and 0 in RMW_WR.
- Handshake: requester holds req/we/addr/wdata/be stable until gnt; gnt high exactly one cycle per accepted request; requester may present a new request the cycle after gnt.
- Read grant in cycle N: mem_re = 1, mem_r_address = index; rdata <= mem_rd at posedge ending N; rvalid[n] = 1 in cycle N+1 only. Back-to-back reads give one result per cycle.
- Write, be = 4'hF: mem_we = 1, mem_wd = wdata, same cycle as gnt; single cycle, stays IDLE.
- Write, be = 4'h0: granted, no memory access, stays IDLE.
- Write, partial be: cycle N: gnt, mem_re = 1, merge register <= per byte (be ? wdata : mem_rd), latched index; go RMW_WR. Cycle N+1: mem_we = 1 with merged word, busy = 1, no grants; return to IDLE. Atomic: other port cannot intervene.
- Both req in same IDLE cycle: one granted per priority rule, other waits (its req stays high).
- Read and write to the same index on consecutive grants: read after write returns new data.

Optional Feature:
DMEM_ARB_RR_EN. Absent: fixed priority, port 0 always wins ties. Present: round-robin, 1-bit last-grant pointer updated on each gnt, tie goes to the port not last granted; pointer resets to port 1 so port 0 wins first tie.

Decomposition:
Package dmem_arb_pkg: state encoding (IDLE, RMW_WR), BE_FULL = 4'hF, BE_NONE = 4'h0, PORT_CORE = 0, PORT_DMA = 1. Sub-module dmem_byte_merge: combinational 4-lane merge of wdata/mem_rd under be.

Test Plan:
- Reset mid-RMW: partial write granted, rst asserted in RMW_WR -> all outputs 0, target word unchanged on later read.
- Port 0 write 0xDEADBEEF, be F, addr 0x10; then port 0 read 0x10 -> mem_w_address 4, rvalid[0] next cycle, rdata 0xDEADBEEF.
- Word 0x20 = 0x11223344; port 1 write wdata 0xAABBCCDD be 4'b0101 -> 1-cycle busy, port 0 req held off; word becomes 0x11BB33DD.
- Both req every cycle, reads: fixed mode -> only gnt[0]; with DMEM_ARB_RR_EN -> gnt alternates 01,10,01.
- be 0 write to 0x30 holding 0x5 -> gnt pulse, mem_we never high, reads back 0x5.
- addr 0x1003 with MEM_WORDS 1024 -> index 0 (wraps), rvalid returns word 0.
